// File: rtl/regfile_tagged_pkg.sv
// Shared definitions for the tagged architectural register file.
// This file has no ports. It holds default widths, the all-zero data word,
// and the active levels of reset and enable used across the core.
// The REGFILE_COMMIT_BYPASS_EN macro selects the read-port bypass.
// The macro is consumed in regfile_rd_port.sv, not in this file.
package regfile_tagged_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int TAG_W_DEF = 4;
  localparam int NRD_DEF   = 2;

  // Active levels of the core-wide reset and of the per-cycle valid strobes.
  localparam logic RST_ACT = 1'b1;
  localparam logic EN_ACT  = 1'b1;

  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_tagged_if.sv
// Bundles the rename, commit, flush and read-port signals of regfile_tagged.
//
// Handshake semantics:
//   rn_valid, cm_valid and flush are single-cycle qualifiers. There is no ready
//   signal. Every request that is presented at a clk edge is consumed at that
//   edge. The read ports are purely combinational: rd_addr goes in and
//   rd_data, rd_busy and rd_tag come back in the same cycle.
//
// Modports:
//   master : rename/commit/issue side. It drives requests and reads results.
//   slave  : the register file itself.
interface regfile_tagged_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int TAG_W = 4,
  parameter int NRD   = 2
);

  logic                 flush;
  logic                 rn_valid;
  logic [AW-1:0]        rn_addr;
  logic [TAG_W-1:0]     rn_tag;
  logic                 cm_valid;
  logic [AW-1:0]        cm_addr;
  logic [XLEN-1:0]      cm_data;
  logic [TAG_W-1:0]     cm_tag;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TAG_W-1:0] rd_tag;
  logic [AW:0]          busy_cnt;

  modport master (
    output flush, rn_valid, rn_addr, rn_tag,
    output cm_valid, cm_addr, cm_data, cm_tag, rd_addr,
    input  rd_data, rd_busy, rd_tag, busy_cnt
  );

  modport slave (
    input  flush, rn_valid, rn_addr, rn_tag,
    input  cm_valid, cm_addr, cm_data, cm_tag, rd_addr,
    output rd_data, rd_busy, rd_tag, busy_cnt
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port of the tagged register file.
// Ports:
//   rst                          reset. While high, the port returns zero / not busy.
//   addr                         register being read.
//   cm_valid/cm_addr/cm_data/cm_tag  the commit happening in this cycle.
//   reg_data/reg_busy/reg_tag    pre-edge contents of register addr.
//   rd_data/rd_busy/rd_tag       the result.
// Macro REGFILE_COMMIT_BYPASS_EN: when it is defined, a commit in the same
// cycle that would clear the busy bit is forwarded straight to the port.
module regfile_rd_port
  import regfile_tagged_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             rst,
  input  logic [AW-1:0]    addr,
  input  logic             cm_valid,
  input  logic [AW-1:0]    cm_addr,
  input  logic [XLEN-1:0]  cm_data,
  input  logic [TAG_W-1:0] cm_tag,
  input  logic [XLEN-1:0]  reg_data,
  input  logic             reg_busy,
  input  logic [TAG_W-1:0] reg_tag,
  output logic [XLEN-1:0]  rd_data,
  output logic             rd_busy,
  output logic [TAG_W-1:0] rd_tag
);

`ifdef REGFILE_COMMIT_BYPASS_EN
  // Forward only a commit that actually retires the current producer. A stale
  // tag means that a newer rename is still outstanding, so the port keeps
  // reporting busy.
  logic bypass;
  assign bypass = (cm_valid == EN_ACT) && (cm_addr == addr) && reg_busy &&
                  (reg_tag == cm_tag);
`else
  logic unused_cm;
  assign unused_cm = ^{cm_valid, cm_addr, cm_data, cm_tag};
`endif

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    rd_tag  = '0;
    if ((rst == RST_ACT) || (addr == '0)) begin
      rd_data = '0;
      rd_busy = 1'b0;
      rd_tag  = '0;
    end
`ifdef REGFILE_COMMIT_BYPASS_EN
    else if (bypass) begin
      rd_data = cm_data;
      rd_busy = 1'b0;
      rd_tag  = reg_tag;
    end
`endif
    else begin
      rd_data = reg_data;
      rd_busy = reg_busy;
      rd_tag  = reg_tag;
    end
  end

endmodule

// File: rtl/regfile_tagged.sv
// Architectural register file for the out-of-order core. Every register holds
// a data word, a busy bit and a producer tag (ROB index).
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   regfile_tagged_if.slave. It carries flush, rename (rn_*), commit
//         (cm_*), the NRD packed read ports (rd_*) and busy_cnt.
// Macro REGFILE_COMMIT_BYPASS_EN: enables same-cycle commit forwarding on
// the read ports. The state update is the same with or without it.
module regfile_tagged
  import regfile_tagged_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int AW    = AW_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic clk,
  input  logic rst,
  regfile_tagged_if.slave bus
);

  logic [XLEN-1:0]  data_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      cnt_d;

  logic rn_hit;
  logic cm_hit;
  logic cm_clear;

  // x0 is never written and never renamed.
  assign rn_hit   = (bus.rn_valid == EN_ACT) && (bus.rn_addr != '0);
  assign cm_hit   = (bus.cm_valid == EN_ACT) && (bus.cm_addr != '0);
  assign cm_clear = cm_hit && busy_q[bus.cm_addr] &&
                    (tag_q[bus.cm_addr] == bus.cm_tag);

  // Next busy vector. The operations are applied in priority order:
  //   1. A matching-tag commit clears the busy bit.
  //   2. A rename in the same cycle sets it again.
  //   3. A flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (cm_clear) begin
      busy_d[bus.cm_addr] = 1'b0;
    end
    if (bus.flush == EN_ACT) begin
      busy_d = '0;
    end else if (rn_hit) begin
      busy_d[bus.rn_addr] = 1'b1;
    end
  end

  // busy_cnt is the population count of the next busy vector. This gives the
  // required +1/-1/net-0 behaviour for every combination of rename, commit and
  // flush. x0 is never busy, so the count is at most NREG-1.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      // A commit writes its data even when the tag is stale or a flush is
      // present. The ROB only commits values that are architecturally final.
      if (cm_hit) begin
        data_q[bus.cm_addr] <= bus.cm_data;
      end
      if (rn_hit && (bus.flush != EN_ACT)) begin
        tag_q[bus.rn_addr] <= bus.rn_tag;
      end
      busy_q     <= busy_d;
      busy_cnt_q <= cnt_d;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [XLEN-1:0]  p_data;
    logic             p_busy;
    logic [TAG_W-1:0] p_tag;

    assign addr = bus.rd_addr[i*AW +: AW];

    regfile_rd_port #(
      .XLEN  (XLEN),
      .AW    (AW),
      .TAG_W (TAG_W)
    ) u_port (
      .rst      (rst),
      .addr     (addr),
      .cm_valid (bus.cm_valid),
      .cm_addr  (bus.cm_addr),
      .cm_data  (bus.cm_data),
      .cm_tag   (bus.cm_tag),
      .reg_data (data_q[addr]),
      .reg_busy (busy_q[addr]),
      .reg_tag  (tag_q[addr]),
      .rd_data  (p_data),
      .rd_busy  (p_busy),
      .rd_tag   (p_tag)
    );

    assign bus.rd_data[i*XLEN +: XLEN]  = p_data;
    assign bus.rd_busy[i]               = p_busy;
    assign bus.rd_tag[i*TAG_W +: TAG_W] = p_tag;
  end

endmodule

// File: tb/tb_regfile_tagged.sv
// Directed self-checking bench for regfile_tagged with the default
// parameters. Inputs are driven 1 ns after the rising edge. The combinational
// read outputs are sampled 1 ns later, well away from the next rising edge.
module tb_regfile_tagged;

  logic clk;
  logic rst;

  int tests_run;
  int tests_failed;

  regfile_tagged_if #(.XLEN(32), .AW(5), .TAG_W(4), .NRD(2)) bus ();

  regfile_tagged #(
    .XLEN(32), .NREG(32), .AW(5), .TAG_W(4), .NRD(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    bus.flush    = 1'b0;
    bus.rn_valid = 1'b0;
    bus.rn_addr  = '0;
    bus.rn_tag   = '0;
    bus.cm_valid = 1'b0;
    bus.cm_addr  = '0;
    bus.cm_data  = '0;
    bus.cm_tag   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rename(input logic [4:0] a, input logic [3:0] t);
    bus.rn_valid = 1'b1;
    bus.rn_addr  = a;
    bus.rn_tag   = t;
  endtask

  task automatic commit(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
    bus.cm_valid = 1'b1;
    bus.cm_addr  = a;
    bus.cm_tag   = t;
    bus.cm_data  = d;
  endtask

  // Set both read addresses, then let the combinational outputs settle.
  task automatic read2(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
    #1;
  endtask

  function automatic logic [31:0] d0(); return bus.rd_data[31:0];  endfunction
  function automatic logic [31:0] d1(); return bus.rd_data[63:32]; endfunction
  function automatic logic [31:0] b0(); return {31'd0, bus.rd_busy[0]}; endfunction
  function automatic logic [31:0] b1(); return {31'd0, bus.rd_busy[1]}; endfunction
  function automatic logic [31:0] t0(); return {28'd0, bus.rd_tag[3:0]}; endfunction
  function automatic logic [31:0] cnt(); return {26'd0, bus.busy_cnt}; endfunction

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle();
    bus.rd_addr = '0;
    rst = 1'b1;
    tick();
    tick();

    // 1. Reset state.
    read2(5'd5, 5'd5);
    check("rst_comb_data", d0(), 32'h0);
    check("rst_comb_busy", b1(), 32'h0);
    rst = 1'b0;
    tick();
    read2(5'd5, 5'd5);
    check("t1_data_p0", d0(), 32'h0);
    check("t1_data_p1", d1(), 32'h0);
    check("t1_busy_p0", b0(), 32'h0);
    check("t1_busy_p1", b1(), 32'h0);
    check("t1_cnt", cnt(), 32'd0);

    // 2. Rename x5 with tag 3, then commit with the matching tag.
    rename(5'd5, 4'd3);
    tick();
    read2(5'd5, 5'd0);
    check("t2_busy", b0(), 32'h1);
    check("t2_tag", t0(), 32'h3);
    check("t2_data", d0(), 32'h0);
    check("t2_cnt", cnt(), 32'd1);
    commit(5'd5, 4'd3, 32'hDEADBEEF);
    read2(5'd5, 5'd0);
`ifdef REGFILE_COMMIT_BYPASS_EN
    check("t2_byp_data", d0(), 32'hDEADBEEF);
    check("t2_byp_busy", b0(), 32'h0);
`else
    check("t2_nobyp_data", d0(), 32'h0);
    check("t2_nobyp_busy", b0(), 32'h1);
`endif
    check("t2_x0_p1", d1(), 32'h0);
    tick();
    read2(5'd5, 5'd5);
    check("t2_post_data", d1(), 32'hDEADBEEF);
    check("t2_post_busy", b0(), 32'h0);
    check("t2_post_cnt", cnt(), 32'd0);

    // 3. Rename x7 twice, so the first producer's commit becomes stale.
    rename(5'd7, 4'd2);
    tick();
    rename(5'd7, 4'd9);
    tick();
    read2(5'd7, 5'd5);
    check("t3_cnt_rerename", cnt(), 32'd1);
    commit(5'd7, 4'd2, 32'h11);
    read2(5'd7, 5'd5);
    check("t3_stale_nobyp", b0(), 32'h1);
    tick();
    read2(5'd7, 5'd5);
    check("t3_stale_data", d0(), 32'h11);
    check("t3_stale_busy", b0(), 32'h1);
    check("t3_stale_tag", t0(), 32'h9);
    check("t3_stale_cnt", cnt(), 32'd1);
    commit(5'd7, 4'd9, 32'h22);
    read2(5'd7, 5'd5);
`ifdef REGFILE_COMMIT_BYPASS_EN
    check("t3_byp_data", d0(), 32'h22);
`else
    check("t3_nobyp_data", d0(), 32'h11);
`endif
    tick();
    read2(5'd7, 5'd5);
    check("t3_final_data", d0(), 32'h22);
    check("t3_final_busy", b0(), 32'h0);
    check("t3_final_cnt", cnt(), 32'd0);

    // 4. Rename and commit to x4 in the same cycle: rename wins busy/tag.
    rename(5'd4, 4'd1);
    tick();
    rename(5'd4, 4'd6);
    commit(5'd4, 4'd1, 32'h55);
    tick();
    read2(5'd4, 5'd7);
    check("t4_data", d0(), 32'h55);
    check("t4_busy", b0(), 32'h1);
    check("t4_tag", t0(), 32'h6);
    check("t4_cnt", cnt(), 32'd1);
    check("t4_other_port", d1(), 32'h22);
    commit(5'd4, 4'd6, 32'h56);
    tick();

    // 5. Flush with a commit and a rename in the same cycle.
    rename(5'd1, 4'd1);
    tick();
    rename(5'd2, 4'd2);
    tick();
    rename(5'd3, 4'd3);
    tick();
    read2(5'd2, 5'd3);
    check("t5_cnt3", cnt(), 32'd3);
    check("t5_busy_x3", b1(), 32'h1);
    bus.flush = 1'b1;
    commit(5'd2, 4'd2, 32'h77);
    rename(5'd6, 4'd5);
    tick();
    read2(5'd2, 5'd1);
    check("t5_x2_data", d0(), 32'h77);
    check("t5_x2_busy", b0(), 32'h0);
    check("t5_x1_busy", b1(), 32'h0);
    check("t5_cnt0", cnt(), 32'd0);
    read2(5'd6, 5'd3);
    check("t5_ren_ignored", b0(), 32'h0);
    check("t5_x3_busy", b1(), 32'h0);

    // 6. Writes and renames to x0 are ignored, and reset clears pending state.
    rename(5'd0, 4'd4);
    commit(5'd0, 4'd4, 32'hFFFFFFFF);
    read2(5'd0, 5'd0);
    check("t6_x0_bypass", d0(), 32'h0);
    tick();
    read2(5'd0, 5'd0);
    check("t6_x0_data", d0(), 32'h0);
    check("t6_x0_busy", b1(), 32'h0);
    check("t6_x0_cnt", cnt(), 32'd0);
    rename(5'd9, 4'd7);
    tick();
    rename(5'd10, 4'd8);
    tick();
    read2(5'd9, 5'd5);
    check("t6_cnt2", cnt(), 32'd2);
    check("t6_x5_before", d1(), 32'hDEADBEEF);
    rst = 1'b1;
    rename(5'd11, 4'd1);
    read2(5'd9, 5'd5);
    check("t6_rst_comb_busy", b0(), 32'h0);
    check("t6_rst_comb_data", d1(), 32'h0);
    tick();
    rst = 1'b0;
    read2(5'd9, 5'd5);
    check("t6_rst_busy", b0(), 32'h0);
    check("t6_rst_tag", t0(), 32'h0);
    check("t6_rst_data", d1(), 32'h0);
    check("t6_rst_cnt", cnt(), 32'd0);
    read2(5'd11, 5'd10);
    check("t6_rst_ren", b0(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
